// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vend_pkg
//  Brief    : Shared constants for the vending controller: FSM state
//             encodings and coin-acceptor codes.
//  Revision : 1.0 - initial release
// ============================================================================
package vend_pkg;

    // FSM state encodings; all four codes of the 2-bit field are used
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_accum  = 2'd1;
    localparam logic [1:0] c_st_vend   = 2'd2;
    localparam logic [1:0] c_st_change = 2'd3;

    // Coin codes as delivered by the acceptor front end
    localparam logic [1:0] c_coin_none  = 2'b00;
    localparam logic [1:0] c_coin_sel_a = 2'b01;
    localparam logic [1:0] c_coin_sel_b = 2'b10;
    localparam logic [1:0] c_coin_sel_c = 2'b11;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_coin_decode.sv
`default_nettype none
// ============================================================================
//  Module   : vend_coin_decode
//  Brief    : Combinational coin code to credit-unit decoder. Code 2'b00
//             decodes as illegal with a zero value.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_coin_decode
    import vend_pkg::*;
#(
    parameter int COIN_A = 1,
    parameter int COIN_B = 2,
    parameter int COIN_C = 4,
    parameter int CW     = 4
) (
    input  logic [1:0]    i_coin_sel,
    output logic [CW-1:0] o_value,
    output logic          o_legal
);

    // Map each legal code to its unit value; the unused code yields zero
    always_comb begin
        o_value = '0;
        o_legal = 1'b0;
        case (i_coin_sel)
            c_coin_sel_a: begin
                o_value = CW'(COIN_A);
                o_legal = 1'b1;
            end
            c_coin_sel_b: begin
                o_value = CW'(COIN_B);
                o_legal = 1'b1;
            end
            c_coin_sel_c: begin
                o_value = CW'(COIN_C);
                o_legal = 1'b1;
            end
            default: begin
                o_value = '0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule : vend_coin_decode
`default_nettype wire

// File: rtl/vend_fsm_param.sv
`default_nettype none
// ============================================================================
//  Module   : vend_fsm_param
//  Brief    : Parametrised vending controller. Accumulates coin credit,
//             requests a product once PRICE is reached, then pays back any
//             surplus or cancelled credit one unit token at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter  int PRICE      = 6,
    parameter  int COIN_A     = 1,
    parameter  int COIN_B     = 2,
    parameter  int COIN_C     = 4,
    parameter  int MAX_CREDIT = 15,
    localparam int CW         = $clog2(MAX_CREDIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coin_valid,
    input  logic [1:0]    coin_sel,
    input  logic          cancel,
    input  logic          vend_ready,
    input  logic          change_ready,
    output logic          vend_valid,
    output logic          change_valid,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          busy
);

    // One extra bit so an overflowing sum is still comparable to the ceiling
    localparam logic [CW:0]   c_max_credit = (CW + 1)'(MAX_CREDIT);
    localparam logic [CW:0]   c_price      = (CW + 1)'(PRICE);
    localparam logic [CW-1:0] c_one        = CW'(1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_credit;
    logic          r_vend_valid;
    logic          r_change_valid;
    logic          r_coin_reject;
    logic          r_busy;

    logic [CW-1:0] w_value;
    logic          w_legal;
    logic [CW-1:0] w_base;
    logic [CW:0]   w_sum;
    logic          w_open;
    logic          w_coin_ok;
    logic          w_reach;

    vend_coin_decode #(
        .COIN_A (COIN_A),
        .COIN_B (COIN_B),
        .COIN_C (COIN_C),
        .CW     (CW)
    ) u_coin_decode (
        .i_coin_sel (coin_sel),
        .o_value    (w_value),
        .o_legal    (w_legal)
    );

    // In IDLE the running total starts from the coin alone
    assign w_base    = (r_state == c_st_idle) ? '0 : r_credit;
    assign w_sum     = {1'b0, w_base} + {1'b0, w_value};
    assign w_open    = (r_state == c_st_idle) || (r_state == c_st_accum);
    assign w_coin_ok = coin_valid && w_legal && w_open && !cancel
                       && (w_sum <= c_max_credit);
    assign w_reach   = (w_sum >= c_price);

    // Controller FSM together with the credit register and all output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_st_idle;
            r_credit       <= '0;
            r_vend_valid   <= 1'b0;
            r_change_valid <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            // Any presented coin that is not taken is pushed back out
            r_coin_reject <= coin_valid && !w_coin_ok;

            case (r_state)
                c_st_idle, c_st_accum: begin
                    if ((r_state == c_st_accum) && cancel) begin
                        // Credit is always non-zero while accumulating
                        r_state        <= c_st_change;
                        r_change_valid <= 1'b1;
                        r_busy         <= 1'b1;
                    end else if (w_coin_ok) begin
                        r_busy <= 1'b1;
                        if (w_reach) begin
                            r_state      <= c_st_vend;
                            r_credit     <= CW'(w_sum - c_price);
                            r_vend_valid <= 1'b1;
                        end else begin
                            r_state  <= c_st_accum;
                            r_credit <= w_sum[CW-1:0];
                        end
                    end
                end

                c_st_vend: begin
                    if (vend_ready) begin
                        r_vend_valid <= 1'b0;
                        if (r_credit != '0) begin
                            r_state        <= c_st_change;
                            r_change_valid <= 1'b1;
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                c_st_change: begin
                    if (r_credit == '0) begin
                        // Nothing left to pay out; leave rather than stall
                        r_state        <= c_st_idle;
                        r_change_valid <= 1'b0;
                        r_busy         <= 1'b0;
                    end else if (change_ready) begin
                        r_credit <= r_credit - c_one;
                        if (r_credit == c_one) begin
                            r_state        <= c_st_idle;
                            r_change_valid <= 1'b0;
                            r_busy         <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state        <= c_st_idle;
                    r_credit       <= '0;
                    r_vend_valid   <= 1'b0;
                    r_change_valid <= 1'b0;
                    r_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign vend_valid   = r_vend_valid;
    assign change_valid = r_change_valid;
    assign coin_reject  = r_coin_reject;
    assign credit       = r_credit;
    assign busy         = r_busy;

endmodule : vend_fsm_param
`default_nettype wire

// File: tb/tb_vend_fsm_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vend_fsm_param
//  Brief    : Scoreboard bench for vend_fsm_param: default build plus two
//             small-credit builds sharing one stimulus bus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vend_fsm_param;

    typedef struct packed {
        logic [3:0] credit;
        logic       vv;
        logic       cv;
        logic       rej;
        logic       busy;
    } obs_t;

    localparam logic [1:0] c_a = 2'b01;
    localparam logic [1:0] c_b = 2'b10;
    localparam logic [1:0] c_c = 2'b11;
    localparam logic [1:0] c_n = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_sel;
    logic       cancel;
    logic       vend_ready;
    logic       change_ready;

    logic       d_vv, d_cv, d_rej, d_busy;
    logic [3:0] d_credit;
    logic       p3_vv, p3_cv, p3_rej, p3_busy;
    logic [2:0] p3_credit;
    logic       p7_vv, p7_cv, p7_rej, p7_busy;
    logic [2:0] p7_credit;

    obs_t exp_q[$];
    obs_t obs_q[$];
    bit   mon_en  = 1'b0;
    int   mon_sel = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    vend_fsm_param u_dut (
        .clk (clk), .rst (rst), .coin_valid (coin_valid), .coin_sel (coin_sel),
        .cancel (cancel), .vend_ready (vend_ready), .change_ready (change_ready),
        .vend_valid (d_vv), .change_valid (d_cv), .coin_reject (d_rej),
        .credit (d_credit), .busy (d_busy)
    );

    vend_fsm_param #(.PRICE(3), .MAX_CREDIT(7)) u_p3 (
        .clk (clk), .rst (rst), .coin_valid (coin_valid), .coin_sel (coin_sel),
        .cancel (cancel), .vend_ready (vend_ready), .change_ready (change_ready),
        .vend_valid (p3_vv), .change_valid (p3_cv), .coin_reject (p3_rej),
        .credit (p3_credit), .busy (p3_busy)
    );

    vend_fsm_param #(.PRICE(7), .MAX_CREDIT(7)) u_p7 (
        .clk (clk), .rst (rst), .coin_valid (coin_valid), .coin_sel (coin_sel),
        .cancel (cancel), .vend_ready (vend_ready), .change_ready (change_ready),
        .vend_valid (p7_vv), .change_valid (p7_cv), .coin_reject (p7_rej),
        .credit (p7_credit), .busy (p7_busy)
    );

    // Capture the selected build's outputs 1 time unit after each edge
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            case (mon_sel)
                1:       obs_q.push_back({1'b0, p3_credit, p3_vv, p3_cv, p3_rej, p3_busy});
                2:       obs_q.push_back({1'b0, p7_credit, p7_vv, p7_cv, p7_rej, p7_busy});
                default: obs_q.push_back({d_credit, d_vv, d_cv, d_rej, d_busy});
            endcase
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected after the edge
    task automatic cyc(input logic cv, input logic [1:0] sel, input logic can,
                       input logic vr, input logic cr, input logic [3:0] ec,
                       input logic evv, input logic ecv, input logic erej,
                       input logic ebusy);
        coin_valid   = cv;
        coin_sel     = sel;
        cancel       = can;
        vend_ready   = vr;
        change_ready = cr;
        exp_q.push_back({ec, evv, ecv, erej, ebusy});
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        obs_t e, o;
        int   k = 0;
        rst = 1'b1;
        cyc(1, c_c, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, c_b, 1, 1, 1,  0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, c_n, 0, 0, 0,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL reset[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL reset[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_vend_exact;
        obs_t e, o;
        int   k = 0;
        cyc(1, c_c, 0, 0, 0,  4, 0, 0, 0, 1);
        cyc(1, c_b, 0, 0, 0,  0, 1, 0, 0, 1);
        cyc(0, c_n, 0, 0, 0,  0, 1, 0, 0, 1);
        cyc(0, c_n, 0, 1, 0,  0, 0, 0, 0, 0);
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL vend_exact[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL vend_exact[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_vend_change;
        obs_t e, o;
        int   k = 0;
        cyc(1, c_c, 0, 0, 0,  4, 0, 0, 0, 1);
        cyc(1, c_c, 0, 0, 0,  2, 1, 0, 0, 1);
        cyc(0, c_n, 0, 0, 1,  2, 1, 0, 0, 1);
        cyc(0, c_n, 0, 1, 0,  2, 0, 1, 0, 1);
        cyc(0, c_n, 0, 0, 1,  1, 0, 1, 0, 1);
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL vend_change[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL vend_change[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_cancel_stall;
        obs_t e, o;
        int   k = 0;
        cyc(1, c_a, 0, 0, 0,  1, 0, 0, 0, 1);
        cyc(1, c_b, 0, 0, 0,  3, 0, 0, 0, 1);
        cyc(0, c_n, 1, 0, 0,  3, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, c_n, i[0], i[1], 0,  3, 0, 1, 0, 1);
        cyc(0, c_n, 0, 0, 1,  2, 0, 1, 0, 1);
        cyc(0, c_n, 0, 0, 1,  1, 0, 1, 0, 1);
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL cancel_stall[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL cancel_stall[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_reject;
        obs_t e, o;
        int   k = 0;
        cyc(1, c_n, 0, 0, 0,  0, 0, 0, 1, 0);
        cyc(0, c_n, 0, 0, 0,  0, 0, 0, 0, 0);
        cyc(0, c_n, 1, 0, 0,  0, 0, 0, 0, 0);
        cyc(1, c_a, 1, 0, 0,  0, 0, 0, 1, 0);
        cyc(1, c_c, 0, 0, 0,  4, 0, 0, 0, 1);
        cyc(1, c_b, 0, 0, 0,  0, 1, 0, 0, 1);
        cyc(1, c_c, 1, 0, 0,  0, 1, 0, 1, 1);
        cyc(0, c_n, 0, 0, 0,  0, 1, 0, 0, 1);
        cyc(0, c_n, 0, 1, 0,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL reject[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL reject[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_cancel_coin;
        obs_t e, o;
        int   k = 0;
        cyc(1, c_b, 0, 0, 0,  2, 0, 0, 0, 1);
        cyc(1, c_a, 1, 0, 0,  2, 0, 1, 1, 1);
        cyc(1, c_a, 0, 0, 1,  1, 0, 1, 1, 1);
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL cancel_coin[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL cancel_coin[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_reset_mid;
        obs_t e, o;
        int   k = 0;
        cyc(1, c_a, 0, 0, 0,  1, 0, 0, 0, 1);
        cyc(1, c_b, 0, 0, 0,  3, 0, 0, 0, 1);
        cyc(0, c_n, 1, 0, 0,  3, 0, 1, 0, 1);
        rst = 1'b1;
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL reset_mid[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL reset_mid[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    // PRICE=3, MAX_CREDIT=7: one C coin overshoots by one unit
    task automatic test_param_price3;
        obs_t e, o;
        int   k = 0;
        mon_sel = 1;
        rst = 1'b1;
        cyc(0, c_n, 0, 0, 0,  0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1, c_c, 0, 0, 0,  1, 1, 0, 0, 1);
        cyc(0, c_n, 0, 1, 0,  1, 0, 1, 0, 1);
        cyc(0, c_n, 0, 0, 1,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL param_price3[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL param_price3[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    // PRICE=7, MAX_CREDIT=7: a sum above the ceiling is refused, exactly at it accepted
    task automatic test_param_overflow;
        obs_t e, o;
        int   k = 0;
        mon_sel = 2;
        rst = 1'b1;
        cyc(0, c_n, 0, 0, 0,  0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(1, c_c, 0, 0, 0,  4, 0, 0, 0, 1);
        cyc(1, c_b, 0, 0, 0,  6, 0, 0, 0, 1);
        cyc(1, c_c, 0, 0, 0,  6, 0, 0, 1, 1);
        cyc(1, c_a, 0, 0, 0,  0, 1, 0, 0, 1);
        cyc(0, c_n, 0, 1, 0,  0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) $display("FAIL param_overflow[%0d]: no sample, required %h", k, e);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL param_overflow[%0d]: got {cr,vv,cv,rej,busy}=%h required %h", k, o, e);
                else n_pass++;
            end
            k++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        coin_valid   = 1'b0;
        coin_sel     = 2'b00;
        cancel       = 1'b0;
        vend_ready   = 1'b0;
        change_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b1;
        test_reset;
        test_vend_exact;
        test_vend_change;
        test_cancel_stall;
        test_reject;
        test_cancel_coin;
        test_reset_mid;
        test_param_price3;
        test_param_overflow;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_vend_fsm_param
`default_nettype wire
